quadrilatero_tile_sequencer: RTL and testbench

// Issue-side counterpart of the matrix-extension instruction decoder. Accepts one

---
 rtl/quadrilatero_tile_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_quadrilatero_tile_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrilatero_tile_sequencer.sv
// quadrilatero_tile_sequencer
// Expands one tile-GEMM command (C[md] = sum_k A_k * B_k) into the encoded
// matrix-extension stream MZERO, K x (MLD_W A, MLD_W B, FMMACC_S), MST_W and
// issues it word by word over a valid/ready port.
// Optional build macro: QUADRILATERO_SEQ_PERF_EN adds accepted-word and
// stall-cycle performance counters.
module quadrilatero_tile_sequencer #(
  parameter int         KCNT_W  = 8,
  parameter int         MREG_W  = 3,
  parameter logic [4:0] RS1_IDX = 5'd10,
  parameter logic [4:0] RS2_IDX = 5'd11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [MREG_W-1:0] cmd_md_i,
  input  logic [MREG_W-1:0] cmd_ms1_i,
  input  logic [MREG_W-1:0] cmd_ms2_i,
  input  logic [KCNT_W-1:0] cmd_k_i,
  input  logic [31:0]       cmd_a_addr_i,
  input  logic [31:0]       cmd_a_step_i,
  input  logic [31:0]       cmd_b_addr_i,
  input  logic [31:0]       cmd_b_step_i,
  input  logic [31:0]       cmd_c_addr_i,
  input  logic [31:0]       cmd_stride_i,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [31:0]       issue_instr_o,
  output logic [31:0]       issue_rs1_o,
  output logic [31:0]       issue_rs2_o,
  output logic              done_o
`ifdef QUADRILATERO_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_instr_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ZERO = 3'd1,
    LDA  = 3'd2,
    LDB  = 3'd3,
    MAC  = 3'd4,
    ST   = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [KCNT_W-1:0] K_ONE  = {{(KCNT_W-1){1'b0}}, 1'b1};
  localparam logic [KCNT_W-1:0] K_ZERO = {KCNT_W{1'b0}};

  state_t              state;
  logic [MREG_W-1:0]   md_r;
  logic [MREG_W-1:0]   ms1_r;
  logic [MREG_W-1:0]   ms2_r;
  logic [KCNT_W-1:0]   k_r;
  logic [KCNT_W-1:0]   kcnt;
  logic [31:0]         a_ptr;
  logic [31:0]         b_ptr;
  logic [31:0]         a_step_r;
  logic [31:0]         b_step_r;
  logic [31:0]         c_addr_r;
  logic [31:0]         stride_r;

  logic                accept;
  logic [KCNT_W-1:0]   kcnt_next;
  logic [31:0]         a_ptr_next;
  logic [31:0]         b_ptr_next;

  assign accept     = issue_valid_o & issue_ready_i;
  assign kcnt_next  = kcnt + K_ONE;
  assign a_ptr_next = a_ptr + a_step_r;
  assign b_ptr_next = b_ptr + b_step_r;

  function automatic logic [31:0] enc_mzero(input logic [MREG_W-1:0] md);
    enc_mzero = {5'b11111, 9'b0, md, 15'b000000000101011};
  endfunction

  function automatic logic [31:0] enc_fmmacc(input logic [MREG_W-1:0] md,
                                             input logic [MREG_W-1:0] ms1,
                                             input logic [MREG_W-1:0] ms2);
    enc_fmmacc = {8'b00001000, ms2, ms1, md, 15'b000100000101011};
  endfunction

  function automatic logic [31:0] enc_mld(input logic [MREG_W-1:0] md);
    enc_mld = {7'b0000010, RS2_IDX, RS1_IDX, 5'b00010, md, 7'b0101011};
  endfunction

  function automatic logic [31:0] enc_mst(input logic [MREG_W-1:0] ms3);
    enc_mst = {7'b0000110, RS2_IDX, RS1_IDX, 5'b00010, ms3, 7'b0101011};
  endfunction

  // Sequencer FSM: accepts a command, then presents the next word each time the current one is taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cmd_ready_o   <= 1'b1;
      issue_valid_o <= 1'b0;
      issue_instr_o <= 32'd0;
      issue_rs1_o   <= 32'd0;
      issue_rs2_o   <= 32'd0;
      done_o        <= 1'b0;
      md_r          <= {MREG_W{1'b0}};
      ms1_r         <= {MREG_W{1'b0}};
      ms2_r         <= {MREG_W{1'b0}};
      k_r           <= K_ZERO;
      kcnt          <= K_ZERO;
      a_ptr         <= 32'd0;
      b_ptr         <= 32'd0;
      a_step_r      <= 32'd0;
      b_step_r      <= 32'd0;
      c_addr_r      <= 32'd0;
      stride_r      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (cmd_valid_i && cmd_ready_o) begin
            md_r          <= cmd_md_i;
            ms1_r         <= cmd_ms1_i;
            ms2_r         <= cmd_ms2_i;
            k_r           <= cmd_k_i;
            kcnt          <= K_ZERO;
            a_ptr         <= cmd_a_addr_i;
            b_ptr         <= cmd_b_addr_i;
            a_step_r      <= cmd_a_step_i;
            b_step_r      <= cmd_b_step_i;
            c_addr_r      <= cmd_c_addr_i;
            stride_r      <= cmd_stride_i;
            cmd_ready_o   <= 1'b0;
            issue_valid_o <= 1'b1;
            issue_instr_o <= enc_mzero(cmd_md_i);
            issue_rs1_o   <= 32'd0;
            issue_rs2_o   <= 32'd0;
            state         <= ZERO;
          end
        end
        ZERO: begin
          if (accept) begin
            if (k_r != K_ZERO) begin
              issue_instr_o <= enc_mld(ms1_r);
              issue_rs1_o   <= a_ptr;
              issue_rs2_o   <= stride_r;
              state         <= LDA;
            end else begin
              issue_instr_o <= enc_mst(md_r);
              issue_rs1_o   <= c_addr_r;
              issue_rs2_o   <= stride_r;
              state         <= ST;
            end
          end
        end
        LDA: begin
          if (accept) begin
            issue_instr_o <= enc_mld(ms2_r);
            issue_rs1_o   <= b_ptr;
            issue_rs2_o   <= stride_r;
            state         <= LDB;
          end
        end
        LDB: begin
          if (accept) begin
            issue_instr_o <= enc_fmmacc(md_r, ms1_r, ms2_r);
            issue_rs1_o   <= 32'd0;
            issue_rs2_o   <= 32'd0;
            state         <= MAC;
          end
        end
        MAC: begin
          if (accept) begin
            a_ptr <= a_ptr_next;
            b_ptr <= b_ptr_next;
            kcnt  <= kcnt_next;
            if (kcnt_next == k_r) begin
              issue_instr_o <= enc_mst(md_r);
              issue_rs1_o   <= c_addr_r;
              issue_rs2_o   <= stride_r;
              state         <= ST;
            end else begin
              // Next A load uses the pointer being advanced this cycle
              issue_instr_o <= enc_mld(ms1_r);
              issue_rs1_o   <= a_ptr_next;
              issue_rs2_o   <= stride_r;
              state         <= LDA;
            end
          end
        end
        ST: begin
          if (accept) begin
            issue_valid_o <= 1'b0;
            issue_instr_o <= 32'd0;
            issue_rs1_o   <= 32'd0;
            issue_rs2_o   <= 32'd0;
            done_o        <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state         <= IDLE;
          cmd_ready_o   <= 1'b1;
          issue_valid_o <= 1'b0;
          done_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef QUADRILATERO_SEQ_PERF_EN
  // Performance counters: words accepted and cycles stalled by the dispatch stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_instr_cnt_o <= 32'd0;
      perf_stall_cnt_o <= 32'd0;
    end else begin
      if (accept) begin
        perf_instr_cnt_o <= perf_instr_cnt_o + 32'd1;
      end
      if (issue_valid_o && !issue_ready_i) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_quadrilatero_tile_sequencer.sv
// Scoreboard bench for quadrilatero_tile_sequencer: directed commands push their
// expected instruction words; a negedge monitor pops and compares accepted words.
module tb_quadrilatero_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_md, cmd_ms1, cmd_ms2;
  logic [7:0]  cmd_k;
  logic [31:0] cmd_a_addr, cmd_a_step, cmd_b_addr, cmd_b_step, cmd_c_addr, cmd_stride;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr, issue_rs1, issue_rs2;
  logic        done;
`ifdef QUADRILATERO_SEQ_PERF_EN
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [95:0] exp_q[$];
  int          ready_mode = 0;
  logic        held_valid = 1'b0;
  logic [95:0] held;

  localparam logic [31:0] W_MZERO = 32'hF800002B;
  localparam logic [31:0] W_LDA   = 32'h04B50A2B;
  localparam logic [31:0] W_LDB   = 32'h04B50AAB;
  localparam logic [31:0] W_MAC   = 32'h08B0082B;
  localparam logic [31:0] W_MST   = 32'h0CB5082B;

  quadrilatero_tile_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_md_i      (cmd_md),
    .cmd_ms1_i     (cmd_ms1),
    .cmd_ms2_i     (cmd_ms2),
    .cmd_k_i       (cmd_k),
    .cmd_a_addr_i  (cmd_a_addr),
    .cmd_a_step_i  (cmd_a_step),
    .cmd_b_addr_i  (cmd_b_addr),
    .cmd_b_step_i  (cmd_b_step),
    .cmd_c_addr_i  (cmd_c_addr),
    .cmd_stride_i  (cmd_stride),
    .issue_valid_o (issue_valid),
    .issue_ready_i (issue_ready),
    .issue_instr_o (issue_instr),
    .issue_rs1_o   (issue_rs1),
    .issue_rs2_o   (issue_rs2),
    .done_o        (done)
`ifdef QUADRILATERO_SEQ_PERF_EN
    ,
    .perf_instr_cnt_o (perf_instr_cnt),
    .perf_stall_cnt_o (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_q.push_back({instr, rs1, rs2});
  endtask

  // Monitor: compare accepted words against the scoreboard and check stall stability
  always @(negedge clk) begin
    logic [95:0] e;
    if (rst) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check1("valid_held", issue_valid, 1'b1);
        check("instr_held", issue_instr, held[95:64]);
        check("rs1_held", issue_rs1, held[63:32]);
        check("rs2_held", issue_rs2, held[31:0]);
      end
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none", issue_instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", issue_instr, e[95:64]);
          check("rs1", issue_rs1, e[63:32]);
          check("rs2", issue_rs2, e[31:0]);
        end
      end
      if (issue_valid) check1("cmd_ready_busy", cmd_ready, 1'b0);
      if (done) begin
        check("q_empty_at_done", exp_q.size(), 32'd0);
        check1("cmd_ready_at_done", cmd_ready, 1'b0);
        check1("valid_at_done", issue_valid, 1'b0);
      end
      held_valid = issue_valid && !issue_ready;
      held = {issue_instr, issue_rs1, issue_rs2};
    end
  end

  // Random ready generator (about 30% ready) when enabled
  always @(posedge clk) begin
    if (ready_mode == 1) begin
      #1;
      issue_ready = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic send_cmd(input logic [2:0] md, input logic [2:0] ms1, input logic [2:0] ms2,
                          input logic [7:0] k, input logic [31:0] a, input logic [31:0] as,
                          input logic [31:0] b, input logic [31:0] bs, input logic [31:0] c,
                          input logic [31:0] st);
    int n;
    n = 0;
    @(negedge clk);
    cmd_md = md; cmd_ms1 = ms1; cmd_ms2 = ms2; cmd_k = k;
    cmd_a_addr = a; cmd_a_step = as; cmd_b_addr = b; cmd_b_step = bs;
    cmd_c_addr = c; cmd_stride = st;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s done_timeout actual=0 expected=1", name);
    end else begin
      @(negedge clk);
      check1("done_one_cycle", done, 1'b0);
      check1("cmd_ready_after_done", cmd_ready, 1'b1);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1; cmd_valid = 1'b0; issue_ready = 1'b1;
    cmd_md = 3'd0; cmd_ms1 = 3'd0; cmd_ms2 = 3'd0; cmd_k = 8'd0;
    cmd_a_addr = 32'd0; cmd_a_step = 32'd0; cmd_b_addr = 32'd0; cmd_b_step = 32'd0;
    cmd_c_addr = 32'd0; cmd_stride = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    check1("rst_valid", issue_valid, 1'b0);
    check("rst_instr", issue_instr, 32'd0);
    check("rst_rs1", issue_rs1, 32'd0);
    check("rst_rs2", issue_rs2, 32'd0);
    check1("rst_done", done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: k=1 basic stream
    push(W_MZERO, 32'd0, 32'd0);
    push(W_LDA, 32'h1000, 32'd16);
    push(W_LDB, 32'h2000, 32'd16);
    push(W_MAC, 32'd0, 32'd0);
    push(W_MST, 32'h3000, 32'd16);
    send_cmd(3'd0, 3'd4, 3'd5, 8'd1, 32'h1000, 32'h40, 32'h2000, 32'h80, 32'h3000, 32'd16);
    wait_done("t1");

    // 2: k=3 with pointer stepping
    push(W_MZERO, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      push(W_LDA, 32'h1000 + 32'h40 * i, 32'd16);
      push(W_LDB, 32'h2000 + 32'h80 * i, 32'd16);
      push(W_MAC, 32'd0, 32'd0);
    end
    push(W_MST, 32'h3000, 32'd16);
    send_cmd(3'd0, 3'd4, 3'd5, 8'd3, 32'h1000, 32'h40, 32'h2000, 32'h80, 32'h3000, 32'd16);
    wait_done("t2");

    // 3: k=0 -> MZERO then MST only
    push(W_MZERO, 32'd0, 32'd0);
    push(W_MST, 32'h3000, 32'd16);
    send_cmd(3'd0, 3'd4, 3'd5, 8'd0, 32'h1000, 32'h40, 32'h2000, 32'h80, 32'h3000, 32'd16);
    wait_done("t3");

    // 4: random ready, other registers, A pointer wraps at 32 bits
    ready_mode = 1;
    push(32'hF801802B, 32'd0, 32'd0);
    push(32'h04B508AB, 32'hFFFFFFF8, 32'd8);
    push(32'h04B5092B, 32'h200, 32'd8);
    push(32'h0845882B, 32'd0, 32'd0);
    push(32'h04B508AB, 32'h00000008, 32'd8);
    push(32'h04B5092B, 32'h220, 32'd8);
    push(32'h0845882B, 32'd0, 32'd0);
    push(32'h0CB509AB, 32'h300, 32'd8);
    send_cmd(3'd3, 3'd1, 3'd2, 8'd2, 32'hFFFFFFF8, 32'h10, 32'h200, 32'h20, 32'h300, 32'd8);
    wait_done("t4");
    ready_mode = 0;
    @(posedge clk);
    #2 issue_ready = 1'b1;

    // 5: reset while the B load is presented
    push(W_MZERO, 32'd0, 32'd0);
    push(W_LDA, 32'h1000, 32'd16);
    push(W_LDB, 32'h2000, 32'd16);
    send_cmd(3'd0, 3'd4, 3'd5, 8'd2, 32'h1000, 32'h40, 32'h2000, 32'h80, 32'h3000, 32'd16);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (issue_valid && issue_instr == W_LDB) begin
        issue_ready = 1'b0;
        found = 1'b1;
      end
    end
    check1("reached_ldb", found, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check1("midrst_valid", issue_valid, 1'b0);
    check1("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_instr", issue_instr, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // 6: restart after reset with exactly two stall cycles on the first word
    push(W_MZERO, 32'd0, 32'd0);
    push(W_LDA, 32'h1000, 32'd16);
    push(W_LDB, 32'h2000, 32'd16);
    push(W_MAC, 32'd0, 32'd0);
    push(W_MST, 32'h3000, 32'd16);
    send_cmd(3'd0, 3'd4, 3'd5, 8'd1, 32'h1000, 32'h40, 32'h2000, 32'h80, 32'h3000, 32'd16);
    repeat (2) @(posedge clk);
    #1 issue_ready = 1'b1;
    wait_done("t6");
`ifdef QUADRILATERO_SEQ_PERF_EN
    check("perf_instr_cnt", perf_instr_cnt, 32'd5);
    check("perf_stall_cnt", perf_stall_cnt, 32'd2);
`endif
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
